// File: rtl/alu_operand_loader.sv
// Operand loader for a switch-driven ALU demo board. It collects operand A, operand B and
// the opcode from the switches on successive load presses, then captures the ALU result
// and flags and holds them for display. The clear button wipes everything back to GET_A.
module alu_operand_loader #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_i,
    input  logic         load_btn_i,
    input  logic         clear_btn_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [3:0]   alucontrol_o,
    input  logic [N-1:0] alu_result_i,
    input  logic [3:0]   alu_flags_i,
    output logic [N-1:0] result_o,
    output logic [3:0]   flags_o,
    output logic         valid_o,
    output logic [2:0]   state_o
);

    typedef enum logic [2:0] {
        StGetA    = 3'd0,
        StGetB    = 3'd1,
        StGetOp   = 3'd2,
        StCapture = 3'd3,
        StShow    = 3'd4
    } state_e;

    state_e       state_q;
    logic [2:0]   load_sync_q;
    logic [2:0]   clear_sync_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [3:0]   op_q;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;
    logic         valid_q;
    logic         load_pulse;
    logic         clear_pulse;

    // Bits [1:0] form the two-flop synchronizer; bit [2] is the edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_sync_q  <= 3'b000;
            clear_sync_q <= 3'b000;
        end else begin
            load_sync_q  <= {load_sync_q[1:0], load_btn_i};
            clear_sync_q <= {clear_sync_q[1:0], clear_btn_i};
        end
    end

    // One single-cycle pulse per press, no matter how long the button is held.
    always_comb begin
        load_pulse  = load_sync_q[1] & ~load_sync_q[2];
        clear_pulse = clear_sync_q[1] & ~clear_sync_q[2];
    end

    // Sequencing FSM with registered outputs; clear takes priority over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StGetA;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else if (clear_pulse) begin
            state_q  <= StGetA;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                StGetA: begin
                    if (load_pulse) begin
                        a_q     <= sw_i;
                        state_q <= StGetB;
                    end
                end
                StGetB: begin
                    if (load_pulse) begin
                        b_q     <= sw_i;
                        state_q <= StGetOp;
                    end
                end
                StGetOp: begin
                    if (load_pulse) begin
                        op_q    <= sw_i[3:0];
                        state_q <= StCapture;
                    end
                end
                // One settle cycle for the ALU; loads arriving here are dropped.
                StCapture: begin
                    result_q <= alu_result_i;
                    flags_q  <= alu_flags_i;
                    valid_q  <= 1'b1;
                    state_q  <= StShow;
                end
                // A new A operand starts the next calculation; the old result stays on display.
                StShow: begin
                    if (load_pulse) begin
                        a_q     <= sw_i;
                        valid_q <= 1'b0;
                        state_q <= StGetB;
                    end
                end
                default: begin
                    state_q  <= StGetA;
                    a_q      <= '0;
                    b_q      <= '0;
                    op_q     <= '0;
                    result_q <= '0;
                    flags_q  <= '0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        a_o          = a_q;
        b_o          = b_q;
        alucontrol_o = op_q;
        result_o     = result_q;
        flags_o      = flags_q;
        valid_o      = valid_q;
        state_o      = state_q;
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader (N=4): load sequence, press latency, held button,
// clear/load collision, SHOW reload, asynchronous reset and narrow button pulses.
module tb_alu_operand_loader;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_i;
    logic       load_btn_i;
    logic       clear_btn_i;
    logic [3:0] a_o;
    logic [3:0] b_o;
    logic [3:0] alucontrol_o;
    logic [3:0] alu_result_i;
    logic [3:0] alu_flags_i;
    logic [3:0] result_o;
    logic [3:0] flags_o;
    logic       valid_o;
    logic [2:0] state_o;

    int checks;
    int failures;

    alu_operand_loader #(.N(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_i         (sw_i),
        .load_btn_i   (load_btn_i),
        .clear_btn_i  (clear_btn_i),
        .a_o          (a_o),
        .b_o          (b_o),
        .alucontrol_o (alucontrol_o),
        .alu_result_i (alu_result_i),
        .alu_flags_i  (alu_flags_i),
        .result_o     (result_o),
        .flags_o      (flags_o),
        .valid_o      (valid_o),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single press; returns #1 after the edge at which the load is committed.
    task automatic press(input logic [3:0] sw);
        @(posedge clk); #2;
        sw_i       = sw;
        load_btn_i = 1'b1;
        @(posedge clk); #2;
        load_btn_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        load_btn_i  = 1'b0;
        clear_btn_i = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sw_i = 4'hF; alu_result_i = 4'hF; alu_flags_i = 4'hF;
        load_btn_i = 1'b0; clear_btn_i = 1'b0;
        rst_n = 1'b0;
        #3;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        checks++; if ({a_o, b_o, alucontrol_o, result_o, flags_o} !== 20'h0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", {a_o, b_o, alucontrol_o, result_o, flags_o}); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        // 3 + 5 = 8 in 4 bits: N=1, V=1, C=0, Z=0 -> {C,N,V,Z} = 4'b0110
        alu_result_i = 4'h8; alu_flags_i = 4'b0110;
        press(4'd3);
        checks++; if (a_o !== 4'd3 || state_o !== 3'd1) begin failures++; $display("FAIL seq_a got a=%0h st=%0d exp a=3 st=1", a_o, state_o); end
        press(4'd5);
        checks++; if (b_o !== 4'd5 || state_o !== 3'd2) begin failures++; $display("FAIL seq_b got b=%0h st=%0d exp b=5 st=2", b_o, state_o); end
        // Third press with latency checks around every edge.
        @(posedge clk); #2;
        sw_i = 4'd0; load_btn_i = 1'b1;
        @(posedge clk); #2;
        load_btn_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL seq_latency got st=%0d exp=2", state_o); end
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd3 || valid_o !== 1'b0 || alucontrol_o !== 4'd0) begin failures++; $display("FAIL seq_capture got st=%0d v=%0b op=%0h exp st=3 v=0 op=0", state_o, valid_o, alucontrol_o); end
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd4 || valid_o !== 1'b1) begin failures++; $display("FAIL seq_show got st=%0d v=%0b exp st=4 v=1", state_o, valid_o); end
        checks++; if (result_o !== 4'h8 || flags_o !== 4'b0110) begin failures++; $display("FAIL seq_result got r=%0h f=%0h exp r=8 f=6", result_o, flags_o); end
        // Result must not keep tracking the ALU once captured.
        alu_result_i = 4'h1; alu_flags_i = 4'h1;
        repeat (3) @(posedge clk); #1;
        checks++; if (result_o !== 4'h8 || flags_o !== 4'b0110 || state_o !== 3'd4) begin failures++; $display("FAIL seq_hold got r=%0h f=%0h st=%0d exp r=8 f=6 st=4", result_o, flags_o, state_o); end
    endtask

    task automatic test_show_reload();
        press(4'd9);
        checks++; if (a_o !== 4'd9 || b_o !== 4'd5 || state_o !== 3'd1) begin failures++; $display("FAIL reload_ops got a=%0h b=%0h st=%0d exp a=9 b=5 st=1", a_o, b_o, state_o); end
        checks++; if (valid_o !== 1'b0 || result_o !== 4'h8 || flags_o !== 4'b0110) begin failures++; $display("FAIL reload_result got v=%0b r=%0h f=%0h exp v=0 r=8 f=6", valid_o, result_o, flags_o); end
    endtask

    task automatic test_clear_load();
        press(4'd1);
        checks++; if (b_o !== 4'd1 || state_o !== 3'd2) begin failures++; $display("FAIL clr_setup got b=%0h st=%0d exp b=1 st=2", b_o, state_o); end
        sw_i = 4'd7;
        @(posedge clk); #2;
        load_btn_i = 1'b1; clear_btn_i = 1'b1;
        @(posedge clk); #2;
        load_btn_i = 1'b0; clear_btn_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd0 || valid_o !== 1'b0) begin failures++; $display("FAIL clr_state got st=%0d v=%0b exp st=0 v=0", state_o, valid_o); end
        checks++; if ({a_o, b_o, alucontrol_o, result_o, flags_o} !== 20'h0) begin failures++; $display("FAIL clr_outputs got=%0h exp=0", {a_o, b_o, alucontrol_o, result_o, flags_o}); end
    endtask

    task automatic test_hold();
        sw_i = 4'd7;
        @(posedge clk); #2;
        load_btn_i = 1'b1;
        repeat (50) @(posedge clk);
        #2;
        load_btn_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (a_o !== 4'd7 || state_o !== 3'd1 || b_o !== 4'd0) begin failures++; $display("FAIL hold got a=%0h b=%0h st=%0d exp a=7 b=0 st=1", a_o, b_o, state_o); end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (state_o !== 3'd0 || a_o !== 4'd0) begin failures++; $display("FAIL async_rst got a=%0h st=%0d exp a=0 st=0", a_o, state_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd4);
        checks++; if (a_o !== 4'd4 || b_o !== 4'd0 || state_o !== 3'd1 || valid_o !== 1'b0) begin failures++; $display("FAIL rst_discard got a=%0h b=%0h st=%0d v=%0b exp a=4 b=0 st=1 v=0", a_o, b_o, state_o, valid_o); end
    endtask

    task automatic test_narrow_pulse();
        sw_i = 4'd2;
        @(posedge clk); #1;
        load_btn_i = 1'b1;
        #9;
        load_btn_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (!((state_o === 3'd1 && b_o === 4'd0) || (state_o === 3'd2 && b_o === 4'd2)) || a_o !== 4'd4) begin failures++; $display("FAIL narrow got a=%0h b=%0h st=%0d exp a=4 and (st=1,b=0 or st=2,b=2)", a_o, b_o, state_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // 1 + 2 = 3: no flags set.
        alu_result_i = 4'h3; alu_flags_i = 4'b0000;
        press(4'd1);
        press(4'd2);
        press(4'd6);
        checks++; if (state_o !== 3'd3 || alucontrol_o !== 4'd6) begin failures++; $display("FAIL b2b_capture got st=%0d op=%0h exp st=3 op=6", state_o, alucontrol_o); end
        @(posedge clk); #1;
        checks++; if (state_o !== 3'd4 || valid_o !== 1'b1 || result_o !== 4'h3 || flags_o !== 4'h0) begin failures++; $display("FAIL b2b_show got st=%0d v=%0b r=%0h f=%0h exp st=4 v=1 r=3 f=0", state_o, valid_o, result_o, flags_o); end
        checks++; if (a_o !== 4'd1 || b_o !== 4'd2) begin failures++; $display("FAIL b2b_ops got a=%0h b=%0h exp a=1 b=2", a_o, b_o); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sequence();
        test_show_reload();
        test_clear_load();
        test_hold();
        test_async_reset();
        test_narrow_pulse();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
